// File: rtl/branch_resolve.sv
// Branch condition evaluation against stored or same-cycle flags, with a
// registered one-cycle redirect to fetch and saturating branch statistics.
module branch_resolve #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       cond,
  input  logic [8:0]       imm9,
  input  logic [15:0]      pc_next,
  input  logic [15:0]      rs_data,
  input  logic             Z,
  input  logic             V,
  input  logic             N,
  input  logic             Z_en,
  input  logic             Z_set,
  input  logic             V_en,
  input  logic             V_set,
  input  logic             N_en,
  input  logic             N_set,
  output logic             redirect,
  output logic [15:0]      target_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    RESOLVE  = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state;
  logic        zf;
  logic        vf;
  logic        nf;
  logic        cond_true;
  logic        accept;
  logic        take;
  logic [15:0] offset;
  logic [15:0] next_target;

  assign zf = Z_en ? Z_set : Z;
  assign vf = V_en ? V_set : V;
  assign nf = N_en ? N_set : N;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = ~zf;
      3'b001:  cond_true = zf;
      3'b010:  cond_true = ~zf & ~nf;
      3'b011:  cond_true = nf;
      3'b100:  cond_true = zf | (~zf & ~nf);
      3'b101:  cond_true = nf | zf;
      3'b110:  cond_true = vf;
      3'b111:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Word offset: sign-extend the 9-bit immediate and scale by 2 bytes.
  assign offset      = {{6{imm9[8]}}, imm9, 1'b0};
  assign next_target = br_is_reg ? rs_data : (pc_next + offset);

  // The slot after a redirect is wrong-path, so only RESOLVE accepts branches.
  assign accept = br_valid && (state == RESOLVE);
  assign take   = accept && cond_true;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESOLVE;
      redirect    <= 1'b0;
      target_pc   <= '0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      state    <= take ? REDIRECT : RESOLVE;
      redirect <= take;
      if (take) begin
        target_pc <= next_target;
      end
      if (accept && (br_count != '1)) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (take && (taken_count != '1)) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve: table of hand-computed branches,
// a condition sweep, and hand-written multi-cycle sequences.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_is_reg;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] pc_next;
  logic [15:0] rs_data;
  logic        Z, V, N;
  logic        Z_en, Z_set, V_en, V_set, N_en, N_set;

  logic        redirect;
  logic [15:0] target_pc;
  logic [15:0] br_count;
  logic [15:0] taken_count;
  logic        redirect4;
  logic [15:0] target_pc4;
  logic [3:0]  br_count4;
  logic [3:0]  taken_count4;

  int total = 0;
  int bad   = 0;

  int          exp_br;
  int          exp_tk;
  logic [15:0] exp_tgt;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .cond(cond), .imm9(imm9), .pc_next(pc_next), .rs_data(rs_data),
    .Z(Z), .V(V), .N(N),
    .Z_en(Z_en), .Z_set(Z_set), .V_en(V_en), .V_set(V_set),
    .N_en(N_en), .N_set(N_set),
    .redirect(redirect), .target_pc(target_pc),
    .br_count(br_count), .taken_count(taken_count)
  );

  branch_resolve #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .cond(cond), .imm9(imm9), .pc_next(pc_next), .rs_data(rs_data),
    .Z(Z), .V(V), .N(N),
    .Z_en(Z_en), .Z_set(Z_set), .V_en(V_en), .V_set(V_set),
    .N_en(N_en), .N_set(N_set),
    .redirect(redirect4), .target_pc(target_pc4),
    .br_count(br_count4), .taken_count(taken_count4)
  );

  typedef struct {
    logic        is_reg;
    logic [2:0]  c;
    logic [8:0]  imm;
    logic [15:0] pc;
    logic [15:0] rs;
    logic        z, v, n;
    logic        zen, zset, ven, vset, nen, nset;
    logic        exp_taken;
    logic [15:0] exp_target;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    br_valid = 1'b0; br_is_reg = 1'b0; cond = 3'b000; imm9 = '0;
    pc_next = '0; rs_data = '0; Z = 1'b0; V = 1'b0; N = 1'b0;
    Z_en = 1'b0; Z_set = 1'b0; V_en = 1'b0; V_set = 1'b0;
    N_en = 1'b0; N_set = 1'b0;
  endtask

  task automatic model_reset();
    exp_br = 0; exp_tk = 0; exp_tgt = 16'h0000;
  endtask

  function automatic logic cond_model(input logic [2:0] c, input logic z, input logic v,
                                      input logic n);
    case (c)
      3'd0: return (z == 1'b0);
      3'd1: return (z == 1'b1);
      3'd2: return (z == 1'b0) && (n == 1'b0);
      3'd3: return (n == 1'b1);
      3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
      3'd5: return (n == 1'b1) || (z == 1'b1);
      3'd6: return (v == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  // One accepted branch from RESOLVE, then an idle cycle back to RESOLVE.
  task automatic run_vec(input vec_t t, input string name);
    br_valid = 1'b1; br_is_reg = t.is_reg; cond = t.c; imm9 = t.imm;
    pc_next = t.pc; rs_data = t.rs; Z = t.z; V = t.v; N = t.n;
    Z_en = t.zen; Z_set = t.zset; V_en = t.ven; V_set = t.vset;
    N_en = t.nen; N_set = t.nset;
    @(posedge clk); #1;
    clear_inputs();
    if (exp_br < 65535) exp_br++;
    if (t.exp_taken) begin
      if (exp_tk < 65535) exp_tk++;
      exp_tgt = t.exp_target;
    end
    chk({name, " redirect"}, 32'(redirect), 32'(t.exp_taken));
    chk({name, " target"}, 32'(target_pc), 32'(exp_tgt));
    chk({name, " br_count"}, 32'(br_count), 32'(exp_br));
    chk({name, " taken_count"}, 32'(taken_count), 32'(exp_tk));
    @(posedge clk); #1;
    chk({name, " redirect_clear"}, 32'(redirect), 32'd0);
  endtask

  initial begin
    vec_t t;
    //           reg c     imm     pc        rs        z  v  n  zen zs ven vs nen ns tk tgt
    vecs[0] = '{1'b0, 3'd7, 9'h1FF, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h000E};
    vecs[1] = '{1'b0, 3'd1, 9'h010, 16'h0100, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0120};
    vecs[2] = '{1'b0, 3'd1, 9'h020, 16'h0500, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[3] = '{1'b0, 3'd2, 9'h000, 16'h0200, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200};
    vecs[4] = '{1'b0, 3'd5, 9'h004, 16'h0600, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[5] = '{1'b0, 3'd6, 9'h100, 16'h0300, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100};
    vecs[6] = '{1'b1, 3'd7, 9'h005, 16'h0700, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF};
    vecs[7] = '{1'b0, 3'd7, 9'h002, 16'hFFFE, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
    vecs[8] = '{1'b0, 3'd3, 9'h0FF, 16'h0400, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h05FE};
    vecs[9] = '{1'b0, 3'd6, 9'h001, 16'h0800, 16'h0000, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000};

    clear_inputs();
    rst = 1'b1;
    br_valid = 1'b1; cond = 3'd7; pc_next = 16'h1234; imm9 = 9'h004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    chk("reset redirect", 32'(redirect), 32'd0);
    chk("reset target", 32'(target_pc), 32'h0);
    chk("reset br_count", 32'(br_count), 32'd0);
    chk("reset taken_count", 32'(taken_count), 32'd0);
    chk("reset br_count4", 32'(br_count4), 32'd0);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        fl = 3'(f);
        t = '{1'b0, 3'(c), 9'h000, 16'h1000 + 16'(c * 16 + f * 2), 16'h0000,
              fl[2], fl[1], fl[0], 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000};
        t.exp_taken  = cond_model(3'(c), fl[2], fl[1], fl[0]);
        t.exp_target = t.pc;
        run_vec(t, $sformatf("sweep c%0d f%0d", c, f));
      end
    end

    // Back-to-back: the second valid cycle falls in REDIRECT and is dropped.
    br_valid = 1'b1; cond = 3'd7; pc_next = 16'h2000; imm9 = 9'h001;
    @(posedge clk); #1;
    exp_br++; exp_tk++; exp_tgt = 16'h2002;
    chk("b2b first redirect", 32'(redirect), 32'd1);
    chk("b2b first target", 32'(target_pc), 32'(exp_tgt));
    pc_next = 16'h3000;
    @(posedge clk); #1;
    chk("b2b second redirect", 32'(redirect), 32'd0);
    chk("b2b second target", 32'(target_pc), 32'(exp_tgt));
    chk("b2b second br_count", 32'(br_count), 32'(exp_br));
    pc_next = 16'h4000; imm9 = 9'h000;
    @(posedge clk); #1;
    exp_br++; exp_tk++; exp_tgt = 16'h4000;
    chk("b2b third redirect", 32'(redirect), 32'd1);
    chk("b2b third target", 32'(target_pc), 32'(exp_tgt));
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle redirect", 32'(redirect), 32'd0);
      chk("idle target", 32'(target_pc), 32'(exp_tgt));
      chk("idle br_count", 32'(br_count), 32'(exp_br));
      chk("idle taken_count", 32'(taken_count), 32'(exp_tk));
    end

    // Reset while a redirect is pending, with a taken branch presented.
    br_valid = 1'b1; cond = 3'd7; pc_next = 16'h5000;
    @(posedge clk); #1;
    chk("prerst redirect", 32'(redirect), 32'd1);
    rst = 1'b1; pc_next = 16'h6000;
    @(posedge clk); #1;
    model_reset();
    chk("rstpend redirect", 32'(redirect), 32'd0);
    chk("rstpend target", 32'(target_pc), 32'h0);
    chk("rstpend br_count", 32'(br_count), 32'd0);
    chk("rstpend taken_count", 32'(taken_count), 32'd0);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;

    t = '{1'b0, 3'd7, 9'h001, 16'h0A00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0A02};
    for (int i = 0; i < 20; i++) run_vec(t, $sformatf("sat%0d", i));
    chk("sat br_count4", 32'(br_count4), 32'hF);
    chk("sat taken_count4", 32'(taken_count4), 32'hF);
    chk("sat br_count16", 32'(br_count), 32'd20);
    chk("sat taken_count16", 32'(taken_count), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
